// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the RV32I execute stage.
//   alu_op_e  : ALU opcode carried on ALUControlE
//   fwd_sel_e : forwarding-mux select carried on ForwardAE/ForwardBE
//   wb_sel_e  : write-back source select carried on ResultSrcE/ResultSrcM
//   Br*       : Funct3 branch-condition encodings
package execute_cycle_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FwdReg = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc4 = 2'b10
  } wb_sel_e;

  localparam logic [2:0] BrEq  = 3'b000;
  localparam logic [2:0] BrNe  = 3'b001;
  localparam logic [2:0] BrLt  = 3'b100;
  localparam logic [2:0] BrGe  = 3'b101;
  localparam logic [2:0] BrLtu = 3'b110;
  localparam logic [2:0] BrGeu = 3'b111;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU.
//   a, b : operands (XLEN)
//   op   : alu_op_e opcode
//   y    : result; undefined opcodes yield 0
module execute_cycle_alu
  import execute_cycle_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] w_shamt;
  assign w_shamt = b[ShW-1:0];

  always_comb begin
    y = '0;
    case (op)
      AluAdd:   y = a + b;
      AluSub:   y = a - b;
      AluSll:   y = a << w_shamt;
      AluSlt:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      AluSltu:  y = {{(XLEN-1){1'b0}}, (a < b)};
      AluXor:   y = a ^ b;
      AluSrl:   y = a >> w_shamt;
      AluSra:   y = $unsigned($signed(a) >>> w_shamt);
      AluOr:    y = a | b;
      AluAnd:   y = a & b;
      AluPassB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline.
//   Inputs : ID/EX bundle (controls, operands, immediate, PCs), forwarding selects, ResultW.
//   PCSrcE/PCTargetE : combinational redirect request and target.
//   rs1_addr_H/rs2_addr_H : source addresses echoed to the hazard unit.
//   *M outputs : registered EX/MEM bundle; ALUResultM doubles as a forwarding source.
//   TakenCnt : count of clock edges on which a redirect was raised.
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int unsigned PC_W  = 13,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             BrE,
  input  logic             JumpE,
  input  logic             JalrE,
  input  logic [2:0]       Funct3E,
  input  logic [3:0]       ALUControlE,
  input  logic [1:0]       ResultSrcE,
  input  logic             op_b_sel_E,
  input  logic [XLEN-1:0]  rs1_E,
  input  logic [XLEN-1:0]  rs2_E,
  input  logic [XLEN-1:0]  immOut_E,
  input  logic [4:0]       rd_addr_E,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [PC_W-1:0]  PCE,
  input  logic [PC_W-1:0]  PCPlus4E,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [XLEN-1:0]  ResultW,
  output logic             PCSrcE,
  output logic [PC_W-1:0]  PCTargetE,
  output logic [4:0]       rs1_addr_H,
  output logic [4:0]       rs2_addr_H,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       rd_addr_M,
  output logic [XLEN-1:0]  ALUResultM,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [PC_W-1:0]  PCPlus4M,
  output logic [CNT_W-1:0] TakenCnt
);

  logic [XLEN-1:0]  w_src_a, w_fwd_b, w_src_b, w_alu_y, w_jalr_sum;
  logic             w_cond;
  logic             r_reg_write, r_mem_write;
  logic [1:0]       r_result_src;
  logic [4:0]       r_rd_addr;
  logic [XLEN-1:0]  r_alu_result, r_write_data;
  logic [PC_W-1:0]  r_pc_plus4;
  logic [CNT_W-1:0] r_taken_cnt;

  // Select 11 falls back to the register value.
  always_comb begin
    unique case (fwd_sel_e'(ForwardAE))
      FwdWb:   w_src_a = ResultW;
      FwdMem:  w_src_a = r_alu_result;
      default: w_src_a = rs1_E;
    endcase
    unique case (fwd_sel_e'(ForwardBE))
      FwdWb:   w_fwd_b = ResultW;
      FwdMem:  w_fwd_b = r_alu_result;
      default: w_fwd_b = rs2_E;
    endcase
  end

  assign w_src_b = op_b_sel_E ? immOut_E : w_fwd_b;

  execute_cycle_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a  (w_src_a),
    .b  (w_src_b),
    .op (alu_op_e'(ALUControlE)),
    .y  (w_alu_y)
  );

  // Branches compare against the forwarded register, never the immediate.
  always_comb begin
    w_cond = 1'b0;
    case (Funct3E)
      BrEq:    w_cond = (w_src_a == w_fwd_b);
      BrNe:    w_cond = (w_src_a != w_fwd_b);
      BrLt:    w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
      BrGe:    w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
      BrLtu:   w_cond = (w_src_a < w_fwd_b);
      BrGeu:   w_cond = (w_src_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrcE     = JumpE | (BrE & w_cond);
  assign w_jalr_sum = w_src_a + immOut_E;
  assign PCTargetE  = JalrE ? {w_jalr_sum[PC_W-1:1], 1'b0} : (PCE + immOut_E[PC_W-1:0]);

  assign rs1_addr_H = rs1_addr_E;
  assign rs2_addr_H = rs2_addr_E;

  // Redirecting instructions are not squashed here: JAL/JALR still write their link.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= '0;
      r_rd_addr    <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd_addr    <= rd_addr_E;
      r_alu_result <= w_alu_y;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= PCPlus4E;
      if (PCSrcE) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;
  assign rd_addr_M  = r_rd_addr;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign TakenCnt   = r_taken_cnt;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: the driver pushes the expected EX/MEM bundle for each
// issued vector; a monitor pops and compares one bundle after each rising edge.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, BrE, JumpE, JalrE, op_b_sel_E;
  logic [2:0]  Funct3E;
  logic [3:0]  ALUControlE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [31:0] rs1_E, rs2_E, immOut_E, ResultW;
  logic [4:0]  rd_addr_E, rs1_addr_E, rs2_addr_E;
  logic [12:0] PCE, PCPlus4E;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [12:0] PCTargetE, PCPlus4M;
  logic [4:0]  rs1_addr_H, rs2_addr_H, rd_addr_M;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, TakenCnt;

  execute_cycle dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BrE(BrE),
    .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E), .ALUControlE(ALUControlE),
    .ResultSrcE(ResultSrcE), .op_b_sel_E(op_b_sel_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .immOut_E(immOut_E), .rd_addr_E(rd_addr_E), .rs1_addr_E(rs1_addr_E),
    .rs2_addr_E(rs2_addr_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .rs1_addr_H(rs1_addr_H), .rs2_addr_H(rs2_addr_H), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .rd_addr_M(rd_addr_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [12:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cnt_m    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("RegWriteM",  {31'd0, RegWriteM}, {31'd0, e.rw});
      chk("MemWriteM",  {31'd0, MemWriteM}, {31'd0, e.mw});
      chk("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, e.rs});
      chk("rd_addr_M",  {27'd0, rd_addr_M}, {27'd0, e.rd});
      chk("ALUResultM", ALUResultM, e.alu);
      chk("WriteDataM", WriteDataM, e.wd);
      chk("PCPlus4M",   {19'd0, PCPlus4M}, {19'd0, e.pc4});
      chk("TakenCnt",   TakenCnt, e.cnt);
    end
  end

  task automatic clr();
    RegWriteE = 0; MemWriteE = 0; BrE = 0; JumpE = 0; JalrE = 0; op_b_sel_E = 0;
    Funct3E = 0; ALUControlE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
    rs1_E = 0; rs2_E = 0; immOut_E = 0; ResultW = 0;
    rd_addr_E = 0; rs1_addr_E = 0; rs2_addr_E = 0; PCE = 0; PCPlus4E = 0;
  endtask

  // Called right after inputs change at a negedge; returns at the following negedge.
  task automatic go(input logic src, input logic [12:0] tgt, input logic rw, input logic mw,
                    input logic [1:0] rs, input logic [4:0] rd, input logic [31:0] alu,
                    input logic [31:0] wd, input logic [12:0] pc4);
    exp_t e;
    #1;
    chk("PCSrcE",    {31'd0, PCSrcE}, {31'd0, src});
    chk("PCTargetE", {19'd0, PCTargetE}, {19'd0, tgt});
    if (src) cnt_m++;
    e = '{rw: rw, mw: mw, rs: rs, rd: rd, alu: alu, wd: wd, pc4: pc4, cnt: cnt_m};
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_TakenCnt", TakenCnt, 32'd0);
    chk("rst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
    chk("rst_PCTargetE", {19'd0, PCTargetE}, 32'd0);
    rst = 1'b1;

    // ADD 5+7 -> x3
    clr(); rs1_E = 5; rs2_E = 7; RegWriteE = 1; rd_addr_E = 3; PCE = 13'h100; PCPlus4E = 13'h104;
    go(0, 13'h100, 1, 0, 2'b00, 3, 32'd12, 32'd7, 13'h104);
    // ADD 100+0 -> x4, sets up MEM forwarding
    clr(); rs1_E = 100; RegWriteE = 1; rd_addr_E = 4;
    go(0, 13'h000, 1, 0, 2'b00, 4, 32'd100, 32'd0, 13'h000);
    // SUB with A from ALUResultM (100), B from ResultW (20)
    clr(); rs1_E = 1; rs2_E = 2; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 20;
    ALUControlE = 4'd1; RegWriteE = 1; rd_addr_E = 5;
    go(0, 13'h000, 1, 0, 2'b00, 5, 32'd80, 32'd20, 13'h000);
    // Both operands from WB
    clr(); ForwardAE = 2'b01; ForwardBE = 2'b01; ResultW = 20;
    go(0, 13'h000, 0, 0, 2'b00, 0, 32'd40, 32'd20, 13'h000);
    // Select 11 behaves as register
    clr(); rs1_E = 3; rs2_E = 4; ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 99;
    go(0, 13'h000, 0, 0, 2'b00, 0, 32'd7, 32'd4, 13'h000);

    // BNE equal operands: not taken
    clr(); rs1_E = 9; rs2_E = 9; BrE = 1; Funct3E = 3'b001; immOut_E = 32'h10;
    PCE = 13'h200; PCPlus4E = 13'h204;
    go(0, 13'h210, 0, 0, 2'b00, 0, 32'd18, 32'd9, 13'h204);
    // BNE differing operands: taken
    rs1_E = 8;
    go(1, 13'h210, 0, 0, 2'b00, 0, 32'd17, 32'd9, 13'h204);
    // BEQ with imm on ALU B: compare still uses the register
    clr(); rs1_E = 9; rs2_E = 9; BrE = 1; Funct3E = 3'b000; immOut_E = 32'h10; op_b_sel_E = 1;
    ALUControlE = 4'd1; PCE = 13'h200;
    go(1, 13'h210, 0, 0, 2'b00, 0, 32'hFFFF_FFF9, 32'd9, 13'h000);

    // JALR 0x0FFF+2 -> 0x1000
    clr(); rs1_E = 32'h0FFF; immOut_E = 2; op_b_sel_E = 1; JumpE = 1; JalrE = 1;
    RegWriteE = 1; rd_addr_E = 1; ResultSrcE = 2'b10; PCE = 13'h300; PCPlus4E = 13'h304;
    go(1, 13'h1000, 1, 0, 2'b10, 1, 32'h1001, 32'd0, 13'h304);
    // JAL with PC wrap
    clr(); PCE = 13'h1FFC; immOut_E = 8; JumpE = 1; RegWriteE = 1; rd_addr_E = 1;
    ResultSrcE = 2'b10; PCPlus4E = 13'h0000;
    go(1, 13'h0004, 1, 0, 2'b10, 1, 32'd0, 32'd0, 13'h0000);

    // ALU ops
    clr(); rs1_E = 32'hFFFF_FFFF; rs2_E = 1; ALUControlE = 4'd3;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd1, 32'd1, 13'h0);
    ALUControlE = 4'd4;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd0, 32'd1, 13'h0);
    clr(); rs1_E = 32'h8000_0000; rs2_E = 4; ALUControlE = 4'd7;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'hF800_0000, 32'd4, 13'h0);
    ALUControlE = 4'd6;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'h0800_0000, 32'd4, 13'h0);
    clr(); rs1_E = 1; rs2_E = 32'h23; ALUControlE = 4'd2;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd8, 32'h23, 13'h0);
    clr(); immOut_E = 32'h1234_5000; op_b_sel_E = 1; ALUControlE = 4'd10;
    go(0, 13'h1000, 0, 0, 2'b00, 0, 32'h1234_5000, 32'd0, 13'h0);
    clr(); rs1_E = 5; rs2_E = 7; ALUControlE = 4'd15;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd0, 32'd7, 13'h0);
    clr(); rs1_E = 32'hF0F0; rs2_E = 32'hFF00; ALUControlE = 4'd5;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'h0FF0, 32'hFF00, 13'h0);
    ALUControlE = 4'd8;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'hFFF0, 32'hFF00, 13'h0);
    ALUControlE = 4'd9;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'hF000, 32'hFF00, 13'h0);

    // Signed/unsigned branch conditions, negative offset
    clr(); rs1_E = 32'hFFFF_FFFF; rs2_E = 1; BrE = 1; Funct3E = 3'b100;
    PCE = 13'h400; immOut_E = 32'hFFFF_FFF0;
    go(1, 13'h3F0, 0, 0, 2'b00, 0, 32'd0, 32'd1, 13'h0);
    Funct3E = 3'b110;
    go(0, 13'h3F0, 0, 0, 2'b00, 0, 32'd0, 32'd1, 13'h0);
    clr(); rs1_E = 5; rs2_E = 5; BrE = 1; Funct3E = 3'b010;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd10, 32'd5, 13'h0);
    clr(); rs1_E = 1; rs2_E = 32'hFFFF_FFFF; BrE = 1; Funct3E = 3'b101;
    go(1, 13'h0, 0, 0, 2'b00, 0, 32'd0, 32'hFFFF_FFFF, 13'h0);
    Funct3E = 3'b111;
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd0, 32'hFFFF_FFFF, 13'h0);

    // Bubble: nothing written, counter held
    clr();
    go(0, 13'h0, 0, 0, 2'b00, 0, 32'd0, 32'd0, 13'h0);
    // Store: write data is B before the imm mux; hazard address echo
    clr(); rs1_E = 32'h100; rs2_E = 32'hDEAD; immOut_E = 4; op_b_sel_E = 1; MemWriteE = 1;
    rs1_addr_E = 7; rs2_addr_E = 9;
    #1;
    chk("rs1_addr_H", {27'd0, rs1_addr_H}, 32'd7);
    chk("rs2_addr_H", {27'd0, rs2_addr_H}, 32'd9);
    go(0, 13'h4, 0, 1, 2'b00, 0, 32'h104, 32'hDEAD, 13'h0);

    // Mid-cycle reset with a jump in flight
    clr(); JumpE = 1; RegWriteE = 1; rd_addr_E = 2; rs1_E = 3;
    #2 rst = 1'b0;
    #1;
    chk("mr_MemWriteM", {31'd0, MemWriteM}, 32'd0);
    chk("mr_ALUResultM", ALUResultM, 32'd0);
    chk("mr_WriteDataM", WriteDataM, 32'd0);
    chk("mr_TakenCnt", TakenCnt, 32'd0);
    cnt_m = 0;
    @(negedge clk);
    chk("mr_hold_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    chk("mr_hold_TakenCnt", TakenCnt, 32'd0);
    rst = 1'b1;
    // First post-reset edge registers what is presented
    clr(); rs1_E = 5; rs2_E = 7; RegWriteE = 1; rd_addr_E = 3;
    go(0, 13'h0, 1, 0, 2'b00, 3, 32'd12, 32'd7, 13'h0);

    clr();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
